// File: rtl/surf_buffer_scheduler_if.sv
// ---------------------------------------------------------------------------
// surf_buffer_scheduler_if
// Bundles the trigger, LAB-controller and event-FIFO signals of the buffer
// scheduler. Signal names follow the scheduler's point of view (_i driven
// towards the scheduler, _o driven by it).
//   slave  : scheduler side (consumes triggers/releases, drives digitize/event)
//   master : environment side (command receiver, LAB controller, bus interface)
// Signals:
//   clr_all_i        synchronous clear
//   trig_i/trig_id_i trigger request and its event ID
//   digitize_done_i  LAB controller finished the active buffer
//   clr_evt_i        oldest committed buffer has been read out
//   digitize_o       one-hot digitize request
//   event_done_o     event-FIFO write strobe, with event_id_o/lab_sel_o/event_flag_o
//   rd_sel_o         readout pointer
//   busy_o           all buffers allocated
//   occupancy_o      buffers allocated
//   drop_cnt_o       rejected trigger count (saturating)
// ---------------------------------------------------------------------------
interface surf_buffer_scheduler_if #(
  parameter int NBUF     = 4,
  parameter int BUF_BITS = 2
);
  logic                clr_all_i;
  logic                trig_i;
  logic [31:0]         trig_id_i;
  logic                digitize_done_i;
  logic                clr_evt_i;
  logic [NBUF-1:0]     digitize_o;
  logic                event_done_o;
  logic [31:0]         event_id_o;
  logic [BUF_BITS-1:0] lab_sel_o;
  logic                event_flag_o;
  logic [BUF_BITS-1:0] rd_sel_o;
  logic                busy_o;
  logic [BUF_BITS:0]   occupancy_o;
  logic [15:0]         drop_cnt_o;

  modport slave (
    input  clr_all_i, trig_i, trig_id_i, digitize_done_i, clr_evt_i,
    output digitize_o, event_done_o, event_id_o, lab_sel_o, event_flag_o,
           rd_sel_o, busy_o, occupancy_o, drop_cnt_o
  );

  modport master (
    output clr_all_i, trig_i, trig_id_i, digitize_done_i, clr_evt_i,
    input  digitize_o, event_done_o, event_id_o, lab_sel_o, event_flag_o,
           rd_sel_o, busy_o, occupancy_o, drop_cnt_o
  );
endinterface

// File: rtl/surf_buffer_scheduler.sv
// ---------------------------------------------------------------------------
// surf_buffer_scheduler
// Allocates the NBUF LAB sample buffers round-robin to incoming triggers,
// requests digitization of the active buffer, writes a commit strobe into the
// event FIFO and holds each buffer until the bus side releases it (clr_evt_i).
// Ports:
//   clk_i  system clock
//   rst_i  asynchronous reset, active-high
//   bus    surf_buffer_scheduler_if.slave (trigger, LAB and event-FIFO signals)
// Build option:
//   SCHED_TIMEOUT_EN  when defined, a DIGITIZE phase lasting DIG_TIMEOUT clocks
//                     without digitize_done_i is force-committed with
//                     event_flag_o=1. Undefined: DIGITIZE waits indefinitely.
// ---------------------------------------------------------------------------
module surf_buffer_scheduler #(
  parameter int NBUF        = 4,
  parameter int BUF_BITS    = 2,
  parameter int DIG_TIMEOUT = 4095
) (
  input logic                     clk_i,
  input logic                     rst_i,
  surf_buffer_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_DIGITIZE, S_COMMIT} state_t;

  localparam logic [BUF_BITS:0] FULL = (BUF_BITS+1)'(NBUF);

  state_t              r_state, w_state_nxt;
  logic [BUF_BITS-1:0] r_wr_ptr, r_rd_ptr;
  logic [BUF_BITS:0]   r_pending, r_occ;
  logic                r_busy;
  logic [NBUF-1:0]     r_digitize, w_digitize_nxt;
  logic                r_event_done, w_event_done_nxt;
  logic                r_flag, w_flag_nxt;
  logic [31:0]         r_event_id;
  logic [BUF_BITS-1:0] r_lab_sel;
  logic [15:0]         r_drop;

  logic                w_accept, w_reject, w_release, w_commit_exit;
  logic                w_done_hit, w_tmo_hit, w_dig_end;
  logic [BUF_BITS:0]   w_occ_nxt, w_pending_nxt;

  assign w_accept      = (r_state == S_IDLE) && bus.trig_i && (r_occ != FULL);
  assign w_reject      = bus.trig_i && !w_accept;
  // Only committed buffers can be released; a digitizing one is never freed.
  assign w_release     = bus.clr_evt_i && (r_pending != '0);
  assign w_commit_exit = (r_state == S_COMMIT);
  assign w_done_hit    = (r_state == S_DIGITIZE) && bus.digitize_done_i;
  assign w_dig_end     = w_done_hit || w_tmo_hit;

  assign w_occ_nxt     = r_occ + (BUF_BITS+1)'(w_accept) - (BUF_BITS+1)'(w_release);
  assign w_pending_nxt = r_pending + (BUF_BITS+1)'(w_commit_exit)
                         - (BUF_BITS+1)'(w_release);

`ifdef SCHED_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  // digitize_done_i on the same edge has priority over the timeout.
  assign w_tmo_hit = (r_state == S_DIGITIZE) && !bus.digitize_done_i &&
                     (r_tmo_cnt >= 16'(DIG_TIMEOUT));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tmo_cnt <= '0;
    end else if (bus.clr_all_i || w_accept) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_DIGITIZE) && (r_tmo_cnt != 16'hFFFF)) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end
`else
  logic [15:0] w_unused_tmo;
  assign w_unused_tmo = 16'(DIG_TIMEOUT);
  assign w_tmo_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else if (bus.clr_all_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept)  w_state_nxt = S_DIGITIZE;
      S_DIGITIZE: if (w_dig_end) w_state_nxt = S_COMMIT;
      S_COMMIT:   w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered FSM outputs
  always_comb begin
    w_digitize_nxt   = r_digitize;
    w_event_done_nxt = 1'b0;
    w_flag_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_digitize_nxt = {{(NBUF-1){1'b0}}, 1'b1} << r_wr_ptr;
      end
      S_DIGITIZE: begin
        if (w_dig_end) begin
          w_digitize_nxt   = '0;
          w_event_done_nxt = 1'b1;
          w_flag_nxt       = w_tmo_hit;
        end
      end
      default: w_digitize_nxt = '0;
    endcase
  end

  // Pointer, occupancy and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_pending    <= '0;
      r_occ        <= '0;
      r_busy       <= 1'b0;
      r_digitize   <= '0;
      r_event_done <= 1'b0;
      r_flag       <= 1'b0;
      r_event_id   <= '0;
      r_lab_sel    <= '0;
      r_drop       <= '0;
    end else if (bus.clr_all_i) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_pending    <= '0;
      r_occ        <= '0;
      r_busy       <= 1'b0;
      r_digitize   <= '0;
      r_event_done <= 1'b0;
      r_flag       <= 1'b0;
      r_event_id   <= '0;
      r_lab_sel    <= '0;
      r_drop       <= '0;
    end else begin
      r_digitize   <= w_digitize_nxt;
      r_event_done <= w_event_done_nxt;
      r_flag       <= w_flag_nxt;
      r_occ        <= w_occ_nxt;
      r_busy       <= (w_occ_nxt == FULL);
      r_pending    <= w_pending_nxt;
      if (w_accept)         r_event_id <= bus.trig_id_i;
      if (w_event_done_nxt) r_lab_sel  <= r_wr_ptr;
      // Pointer width equals log2(NBUF), so the increment wraps by itself.
      if (w_commit_exit)    r_wr_ptr   <= r_wr_ptr + 1'b1;
      if (w_release)        r_rd_ptr   <= r_rd_ptr + 1'b1;
      if (w_reject && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
    end
  end

  assign bus.digitize_o   = r_digitize;
  assign bus.event_done_o = r_event_done;
  assign bus.event_id_o   = r_event_id;
  assign bus.lab_sel_o    = r_lab_sel;
  assign bus.event_flag_o = r_flag;
  assign bus.rd_sel_o     = r_rd_ptr;
  assign bus.busy_o       = r_busy;
  assign bus.occupancy_o  = r_occ;
  assign bus.drop_cnt_o   = r_drop;

endmodule

// File: tb/tb_surf_buffer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_surf_buffer_scheduler
// Directed scenarios followed by randomized traffic, compared every cycle
// against a queue-based behavioural model of buffer allocation.
// ---------------------------------------------------------------------------
module tb_surf_buffer_scheduler;

  localparam int NBUF        = 4;
  localparam int BUF_BITS    = 2;
  localparam int DIG_TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  surf_buffer_scheduler_if #(.NBUF(NBUF), .BUF_BITS(BUF_BITS)) bus ();

  surf_buffer_scheduler #(
    .NBUF(NBUF), .BUF_BITS(BUF_BITS), .DIG_TIMEOUT(DIG_TIMEOUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 digitizing, 2 committing.
  // Committed buffers wait in a FIFO until released.
  int          m_phase;
  int          m_act_buf;
  logic [31:0] m_act_id;
  bit          m_flag;
  int          m_q[$];
  int          m_wr;
  int          m_rel;
  int          m_drop;
`ifdef SCHED_TIMEOUT_EN
  int          m_dig_n;
`endif

  task automatic model_reset();
    m_phase = 0; m_act_buf = 0; m_act_id = '0; m_flag = 1'b0;
    m_q.delete(); m_wr = 0; m_rel = 0; m_drop = 0;
  endtask

  function automatic int model_occ();
    return m_q.size() + ((m_phase != 0) ? 1 : 0);
  endfunction

  task automatic model_step(input bit trig, input logic [31:0] id, input bit done,
                            input bit clr, input bit clr_all);
    bit accept;
    if (clr_all) begin
      model_reset();
      return;
    end
    accept = (m_phase == 0) && trig && (model_occ() < NBUF);
    if (trig && !accept && m_drop < 65535) m_drop++;
    if (clr && m_q.size() > 0) begin
      void'(m_q.pop_front());
      m_rel++;
    end
    if (m_phase == 2) begin
      m_q.push_back(m_act_buf);
      m_wr    = (m_act_buf + 1) % NBUF;
      m_phase = 0;
      m_flag  = 1'b0;
    end else if (m_phase == 1) begin
      if (done) begin
        m_phase = 2; m_flag = 1'b0;
      end
`ifdef SCHED_TIMEOUT_EN
      else if (m_dig_n >= DIG_TIMEOUT) begin
        m_phase = 2; m_flag = 1'b1;
      end else begin
        m_dig_n++;
      end
`endif
    end
    if (accept) begin
      m_phase = 1; m_act_buf = m_wr; m_act_id = id;
`ifdef SCHED_TIMEOUT_EN
      m_dig_n = 0;
`endif
    end
  endtask

  task automatic check_model();
    int occ;
    occ = model_occ();
    chk("digitize", 64'(bus.digitize_o), (m_phase == 1) ? 64'(1 << m_act_buf) : 64'd0);
    chk("event_done", 64'(bus.event_done_o), 64'(m_phase == 2));
    if (m_phase == 2) begin
      chk("event_id", 64'(bus.event_id_o), 64'(m_act_id));
      chk("lab_sel", 64'(bus.lab_sel_o), 64'(m_act_buf));
      chk("event_flag", 64'(bus.event_flag_o), 64'(m_flag));
    end
    chk("rd_sel", 64'(bus.rd_sel_o), 64'(m_rel % NBUF));
    chk("occupancy", 64'(bus.occupancy_o), 64'(occ));
    chk("busy", 64'(bus.busy_o), 64'(occ == NBUF));
    chk("drop_cnt", 64'(bus.drop_cnt_o), 64'(m_drop));
  endtask

  // Drive one cycle of inputs just after a rising edge, advance the model,
  // then sample the DUT 1 ns after the next rising edge.
  task automatic step(input bit trig, input logic [31:0] id, input bit done,
                      input bit clr, input bit clr_all);
    bus.trig_i          = trig;
    bus.trig_id_i       = id;
    bus.digitize_done_i = done;
    bus.clr_evt_i       = clr;
    bus.clr_all_i       = clr_all;
    model_step(trig, id, done, clr, clr_all);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_digitize"},  64'(bus.digitize_o),   64'd0);
    chk({tag, "_event_done"}, 64'(bus.event_done_o), 64'd0);
    chk({tag, "_occupancy"}, 64'(bus.occupancy_o),  64'd0);
    chk({tag, "_rd_sel"},    64'(bus.rd_sel_o),     64'd0);
    chk({tag, "_busy"},      64'(bus.busy_o),       64'd0);
    chk({tag, "_drop"},      64'(bus.drop_cnt_o),   64'd0);
  endtask

  initial begin
    bus.trig_i = 1'b0; bus.trig_id_i = '0; bus.digitize_done_i = 1'b0;
    bus.clr_evt_i = 1'b0; bus.clr_all_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Single event: 5 digitize cycles, commit on the following one.
    step(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
    chk("t1_dig_rise", 64'(bus.digitize_o), 64'h1);
    repeat (4) idle();
    chk("t1_dig_held", 64'(bus.digitize_o), 64'h1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("t1_strobe", 64'(bus.event_done_o), 64'd1);
    chk("t1_id", 64'(bus.event_id_o), 64'h12345678);
    chk("t1_lab", 64'(bus.lab_sel_o), 64'd0);
    chk("t1_dig_fall", 64'(bus.digitize_o), 64'd0);
    idle();
    chk("t1_strobe_end", 64'(bus.event_done_o), 64'd0);

    // Fill all buffers, then one rejected trigger.
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < NBUF; k++) begin
      step(1'b1, 32'hA000 + 32'(k), 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("t2_lab_seq", 64'(bus.lab_sel_o), 64'(k));
      idle();
    end
    chk("t2_busy", 64'(bus.busy_o), 64'd1);
    chk("t2_occ", 64'(bus.occupancy_o), 64'd4);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("t2_drop", 64'(bus.drop_cnt_o), 64'd1);
    chk("t2_no_dig", 64'(bus.digitize_o), 64'd0);

    // Release from full, then wrap to buffer 0.
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("t3_rd_sel", 64'(bus.rd_sel_o), 64'd1);
    chk("t3_occ", 64'(bus.occupancy_o), 64'd3);
    chk("t3_busy", 64'(bus.busy_o), 64'd0);
    step(1'b1, 32'hB0B0, 1'b0, 1'b0, 1'b0);
    chk("t3_dig_wrap", 64'(bus.digitize_o), 64'h1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("t3_lab_wrap", 64'(bus.lab_sel_o), 64'd0);
    idle();

    // Accept and release on the same edge; release with nothing pending.
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("t4_occ2", 64'(bus.occupancy_o), 64'd2);
    step(1'b1, 32'hC0C0, 1'b0, 1'b1, 1'b0);
    chk("t4_occ_same", 64'(bus.occupancy_o), 64'd2);
    chk("t4_rd_wrap", 64'(bus.rd_sel_o), 64'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    idle();
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("t4_occ0", 64'(bus.occupancy_o), 64'd0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("t4_ignored_occ", 64'(bus.occupancy_o), 64'd0);
    chk("t4_ignored_rd", 64'(bus.rd_sel_o), 64'd2);

    // Asynchronous reset while digitizing.
    step(1'b1, 32'h5555, 1'b0, 1'b0, 1'b0);
    idle();
    #4 rst = 1'b1;
    #1;
    check_all_zero("t5_async");
    model_reset();
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("t5_no_strobe", 64'(bus.event_done_o), 64'd0);
    end
    // Synchronous clear wins over a same-cycle done.
    step(1'b1, 32'h6666, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    check_all_zero("t5_clr_all");
    idle();
    chk("t5_clr_no_strobe", 64'(bus.event_done_o), 64'd0);

`ifdef SCHED_TIMEOUT_EN
    begin
      int wait_n;
      bit seen;
      wait_n = 0; seen = 1'b0;
      step(1'b1, 32'h7777, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 40 && !seen; k++) begin
        idle();
        if (bus.event_done_o) begin
          seen = 1'b1; wait_n = k;
        end
      end
      chk("t6_timeout_seen", 64'(seen), 64'd1);
      chk("t6_timeout_cycles", 64'(wait_n), 64'(DIG_TIMEOUT + 1));
      chk("t6_flag", 64'(bus.event_flag_o), 64'd1);
      idle();
    end
`endif

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(2) == 0), 32'($urandom), ($urandom_range(3) == 0),
           ($urandom_range(4) == 0), ($urandom_range(199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
